// File: rtl/gate_sweep_ctrl.sv
// Sequencer that steps a 2-input gate through {a,b} = 0..3, samples y after a
// programmable settle time and compares the captured truth table with EXPECT.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECT        = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx,
  output logic [3:0] result_vec,
  output logic       a,
  output logic       b,
  input  logic       y
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NVEC  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NVEC-1:0]  result_d;
  logic [NVEC-1:0]  mismatch_c;
  logic [IDX_W-1:0] first_bad_c;
  logic             pass_d, done_d, busy_d, a_d, b_d;
  logic [IDX_W-1:0] fail_d;

  // Lowest vector index whose captured value disagrees with EXPECT.
  always_comb begin
    mismatch_c  = result_d ^ EXPECT;
    first_bad_c = '0;
    for (int i = int'(NVEC) - 1; i >= 0; i--) begin
      if (mismatch_c[i]) first_bad_c = IDX_W'(i);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_vec;
    pass_d   = pass;
    fail_d   = fail_idx;

    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = '0;
          pass_d   = 1'b0;
          fail_d   = '0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        result_d[idx_q] = y;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          pass_d  = (result_d == EXPECT);
          fail_d  = first_bad_c;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so derive them from where the FSM is heading.
    done_d = (state_d == DONE);
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    a_d    = busy_d & idx_d[1];
    b_d    = busy_d & idx_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      result_vec <= '0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      result_vec <= result_d;
      pass       <= pass_d;
      fail_idx   <= fail_d;
      done       <= done_d;
      busy       <= busy_d;
      a          <= a_d;
      b          <= b_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with a selectable gate stub
// (SETTLE_CYCLES=1) and one AND-gate instance with SETTLE_CYCLES=3.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       busy1, done1, pass1, a1, b1, y1;
  logic       busy3, done3, pass3, a3, b3, y3;
  logic [1:0] fail1, fail3;
  logic [3:0] rv1, rv3;

  int mode = 0;       // 0: AND, 1: tied 1, 2: OR
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done1_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done1 === 1'b1) done1_cnt <= done1_cnt + 1;

  assign y1 = (mode == 0) ? (a1 & b1) : (mode == 1) ? 1'b1 : (a1 | b1);
  assign y3 = a3 & b3;

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECT(4'b1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_idx(fail1), .result_vec(rv1), .a(a1), .b(b1), .y(y1)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(3), .EXPECT(4'b1000)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .pass(pass3), .fail_idx(fail3), .result_vec(rv3), .a(a3), .b(b3), .y(y3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SETTLE_CYCLES=1 sweep; optional stray start pulses at cycles 2 and 5.
  task automatic sweep1(input int m, input logic [3:0] erv, input logic ep,
                        input logic [1:0] efi, input bit repulse, input string tag);
    int d0;
    mode = m;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    d0 = done1_cnt;
    for (int k = 0; k < 8; k++) begin
      check({tag, " step"}, {busy1, done1, a1, b1}, {2'b10, 2'(k / 2)});
      start1 = repulse && (k == 2 || k == 5);
      @(posedge clk); #1;
    end
    check({tag, " done"}, {busy1, done1}, 2'b01);
    check({tag, " result_vec"}, rv1, erv);
    check({tag, " pass"}, pass1, ep);
    check({tag, " fail_idx"}, fail1, efi);
    @(posedge clk); #1;
    check({tag, " idle"}, {busy1, done1, a1, b1}, 4'b0000);
    check({tag, " hold"}, {rv1, pass1, fail1}, {erv, ep, efi});
    check({tag, " one done"}, done1_cnt - d0, 1);
  endtask

  initial begin
    int c0, got, d0;
    int t[2];
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset dut1", {busy1, done1, pass1, fail1, rv1, a1, b1}, 11'd0);
    check("reset dut3", {busy3, done3, pass3, fail3, rv3, a3, b3}, 11'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    sweep1(0, 4'b1000, 1'b1, 2'd0, 1'b0, "and");
    sweep1(1, 4'b1111, 1'b0, 2'd0, 1'b0, "ones");
    sweep1(2, 4'b1110, 1'b0, 2'd1, 1'b1, "or_repulse");
    sweep1(0, 4'b1000, 1'b1, 2'd0, 1'b1, "and_repulse");

    // start held high: back-to-back sweeps with one IDLE cycle between.
    mode = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    got = 0;
    t[0] = 0; t[1] = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        t[got] = cyc;
        got++;
      end
    end
    start1 = 1'b0;
    check("held two dones", got, 2);
    check("held first latency", t[0] - c0, 8);
    check("held spacing", t[1] - t[0], 10);
    check("held pass", pass1, 1'b1);
    repeat (3) @(posedge clk);

    // SETTLE_CYCLES=3: each vector held 4 cycles, done 16 cycles after start.
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("s3 step", {busy3, done3, a3, b3}, {2'b10, 2'(k / 4)});
      @(posedge clk); #1;
    end
    check("s3 done", {busy3, done3}, 2'b01);
    check("s3 result", {rv3, pass3, fail3}, {4'b1000, 1'b1, 2'd0});

    // Reset during vector 2 aborts the sweep without a done pulse.
    mode = 2;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("pre-reset a/b", {busy1, a1, b1}, 3'b110);
    check("pre-reset result_vec", rv1, 4'b0010);
    d0 = done1_cnt;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {busy1, done1, a1, b1}, 4'b0000);
    check("abort result_vec", rv1, 4'b0000);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort no done", done1_cnt - d0, 0);
    sweep1(0, 4'b1000, 1'b1, 2'd0, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Hardware sequencer that drives a 2-input combinational gate (e.g. and_gate) through all four input vectors and samples its output after a programmable settle time. It compares the sampled truth table against an expected pattern and reports pass/fail plus the first failing vector. It is the on-chip, self-checking replacement for hand-stepped gate benches and sits between a start/done control interface and the gate's a/b/y pins.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling y; legal range 1..15, and 0 is illegal.
EXPECT, 4'b1000, expected y per vector, indexed by {a,b}; the default is the AND truth table.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
busy  output  1  high while a sweep is in progress
done  output  1  single-cycle pulse when a sweep completes
pass  output  1  1 when result_vec == EXPECT; valid from done until the next accepted start
fail_idx  output  2  lowest {a,b} index whose sample mismatched EXPECT; 0 when pass
result_vec  output  4  sampled y values, bit i = y for vector i
a  output  1  gate input a = idx[1]
b  output  1  gate input b = idx[0]
y  input  1  gate output under test

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; busy, done, pass, a, b = 0; fail_idx=0; result_vec=0; vector idx=0; settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a=b=0.
  - On start=1 at a rising edge: clear result_vec, pass, and fail_idx; set idx=0 and cnt=0; go to DRIVE.
- DRIVE:
  - a/b = idx; busy=1.
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - a/b are still held at idx.
  - At the closing edge, result_vec[idx] <= y.
  - If idx==3, go to DONE. Otherwise idx++, cnt=0, and return to DRIVE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass = (result_vec==EXPECT). fail_idx = lowest i where result_vec[i]!=EXPECT[i].
  - Next state is IDLE.
  - done, pass, and fail_idx are registered, so they change coincident with entering DONE.
- Latency: the edge accepting start is edge 0. Each vector takes SETTLE_CYCLES+1 cycles. done is high during the cycle after edge 4*(SETTLE_CYCLES+1). With SETTLE_CYCLES=1, done is high after edge 8.
- start is ignored while busy or in DONE. No queuing, and no re-trigger until back in IDLE.
- start held high continuously produces back-to-back sweeps, with one IDLE cycle between each done and the next DRIVE.
- Output holding:
  - pass, fail_idx, and result_vec hold after done until the next accepted start.
  - a/b return to 0 in IDLE.
- Reset asserted mid-sweep aborts immediately to reset values. No done pulse is generated.
- y is sampled as a plain bit. In simulation, an X on y makes result_vec bit X; the bench must flag this.
- Counter width is 4 bits; idx width is 2 bits and does not wrap, since idx==3 exits to DONE.

Test Plan:
- Real and_gate, SETTLE_CYCLES=1, start pulsed one cycle -> a/b step 00,01,10,11 at 2-cycle spacing; done high 8 cycles after start edge; result_vec=4'b1000, pass=1, fail_idx=0.
- Stub y tied 1 (EXPECT=4'b1000) -> result_vec=4'b1111, pass=0, fail_idx=0.
- Stub computing OR (EXPECT=4'b1000) -> result_vec=4'b1110, pass=0, fail_idx=1.
- SETTLE_CYCLES=3, and_gate -> each vector held 4 cycles; done high 16 cycles after start edge; pass=1.
- start re-pulsed at cycles 2 and 5 of a sweep -> ignored; exactly one done pulse at cycle 8; start held high continuously -> second done 10 cycles after first (one IDLE cycle, then 8 cycles plus the DONE cycle).
- rst_n driven low during vector 2 -> same cycle: busy=0, a=b=0, result_vec=0, no done pulse; after release, a new start completes a normal sweep with pass=1.
